// File: rtl/regfile_dump.sv
// Register-file dump engine: walks every register index, captures each value and
// presents it on a valid/ready stream. Define REGDUMP_SKIP_ZERO_EN to skip index 0.
module regfile_dump #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

`ifdef REGDUMP_SKIP_ZERO_EN
    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(1);
`else
    localparam logic [ADDR_W-1:0] FIRST = '0;
`endif
    localparam logic [ADDR_W-1:0] LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_SEND,
        S_DONE
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic              busy_q;
    logic              done_q;

    always_ff @(posedge clk) begin
        // NOTE: the captured word is reset as well, so nothing stale is visible after an abort.
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        idx_q   <= FIRST;
                        busy_q  <= 1'b1;
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    out_data_q  <= rd_data;
                    out_addr_q  <= idx_q;
                    out_last_q  <= (idx_q == LAST);
                    out_valid_q <= 1'b1;
                    state_q     <= S_SEND;
                end
                S_SEND: begin
                    // The word is held until the consumer takes it; start is ignored here.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (out_last_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_addr   = idx_q;
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: reset values, a cycle table, and randomized
// dumps checked against an expected word list built from a register snapshot.
module tb_regfile_dump;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int NREG   = 2 ** ADDR_W;
`ifdef REGDUMP_SKIP_ZERO_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] regs [NREG];

    int vectors     = 0;
    int miscompares = 0;

    regfile_dump #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    assign rd_data = regs[rd_addr];

    typedef struct {
        bit          start;
        bit          ready;
        bit          exp_valid;
        int          exp_addr;
        logic [63:0] exp_data;
        bit          exp_busy;
        bit          exp_done;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Drives one dump from IDLE to DONE and checks every accepted word against
    // the snapshot taken at start; writes during the dump only touch captured words.
    task automatic run_dump(input int ready_pct, input int stall_at, input int write_at,
                            input bit noise, output int cycles);
        logic [63:0] snap [NREG];
        int          next;
        bit          got_done;
        bit          acc;
        bit          held;
        bit          stalled;
        bit          written;
        int          stall_left;
        logic [ADDR_W-1:0] a;
        logic [63:0] d;
        snap = regs;
        next = FIRST;
        got_done = 1'b0;
        stalled = 1'b0;
        written = 1'b0;
        stall_left = 0;
        start = 1'b1;
        out_ready = ($urandom_range(99) < ready_pct);
        step();
        start = 1'b0;
        cycles = 1;
        check("start_busy", busy, 1);
        check("start_no_valid", out_valid, 0);
        while (!got_done && cycles < 4000) begin
            out_ready = ($urandom_range(99) < ready_pct);
            if (stall_at >= 0 && out_valid && int'(out_addr) == stall_at && !stalled) begin
                stalled = 1'b1;
                stall_left = 5;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end
            if (write_at >= 0 && out_valid && int'(out_addr) == write_at && !written) begin
                regs[write_at] = 64'hDEAD;
                written = 1'b1;
            end
            if (noise) begin
                start = ($urandom_range(3) == 0);
                if (out_valid && $urandom_range(2) == 0)
                    regs[$urandom_range(int'(out_addr), FIRST)] = {$urandom, $urandom};
            end
            held = out_valid;
            acc  = out_valid && out_ready;
            a    = out_addr;
            d    = out_data;
            if (acc) begin
                check("word_addr", out_addr, next);
                check("word_data", out_data, (next < NREG) ? snap[next] : 64'h0);
                check("word_last", out_last, (next == NREG - 1));
                next++;
            end
            step();
            cycles++;
            if (held && !acc) begin
                check("hold_valid", out_valid, 1);
                check("hold_addr", out_addr, a);
                check("hold_data", out_data, d);
            end
            check("done_timing", done, acc && next == NREG);
            if (done) got_done = 1'b1;
            else check("busy_during_dump", busy, 1);
        end
        start = 1'b0;
        check("done_seen", got_done, 1);
        check("word_count", next - FIRST, NREG - FIRST);
        step();
        check("done_one_cycle", done, 0);
        check("idle_busy", busy, 0);
        check("idle_valid", out_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [8];
        int   cyc;
        int   budget;
        bit   saw_done;
        bit   saw_valid;

        for (int i = 0; i < NREG; i++) regs[i] = 64'(i) * 64'h11;

        // Reset has priority over start and out_ready.
        reset = 1'b1;
        start = 1'b1;
        out_ready = 1'b1;
        step();
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_out_data", out_data, 0);
        check("rst_rd_addr", rd_addr, 0);
        step();
        check("rst_busy_hold", busy, 0);
        reset = 1'b0;
        start = 1'b0;
        step();
        check("idle_no_start", busy, 0);

        vecs[0] = '{1, 1, 0, FIRST,     64'h0,                 1, 0};
        vecs[1] = '{0, 0, 1, FIRST,     64'(FIRST) * 64'h11,     1, 0};
        vecs[2] = '{1, 0, 1, FIRST,     64'(FIRST) * 64'h11,     1, 0};
        vecs[3] = '{0, 0, 1, FIRST,     64'(FIRST) * 64'h11,     1, 0};
        vecs[4] = '{0, 1, 0, FIRST + 1, 64'h0,                 1, 0};
        vecs[5] = '{1, 1, 1, FIRST + 1, 64'(FIRST + 1) * 64'h11, 1, 0};
        vecs[6] = '{0, 1, 0, FIRST + 2, 64'h0,                 1, 0};
        vecs[7] = '{0, 0, 1, FIRST + 2, 64'(FIRST + 2) * 64'h11, 1, 0};
        for (int i = 0; i < 8; i++) begin
            start = vecs[i].start;
            out_ready = vecs[i].ready;
            step();
            check($sformatf("tbl%0d_valid", i), out_valid, vecs[i].exp_valid);
            check($sformatf("tbl%0d_rd_addr", i), rd_addr, vecs[i].exp_addr);
            check($sformatf("tbl%0d_busy", i), busy, vecs[i].exp_busy);
            check($sformatf("tbl%0d_done", i), done, vecs[i].exp_done);
            if (vecs[i].exp_valid) begin
                check($sformatf("tbl%0d_out_addr", i), out_addr, vecs[i].exp_addr);
                check($sformatf("tbl%0d_out_data", i), out_data, vecs[i].exp_data);
            end
        end
        do_reset();

        // Full dump with ready held high: fixed latency start to done.
        run_dump(100, -1, -1, 0, cyc);
        check("dump_cycles", cyc, 2 * (NREG - FIRST) + 1);

        // Stall on word 3, overwrite x7 while its word is held.
        run_dump(100, 3, 7, 0, cyc);
        // Next dump must show the new x7 value.
        run_dump(100, -1, -1, 0, cyc);

        // Reset while word 12 is presented aborts the dump.
        start = 1'b1;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        budget = 0;
        while (!(out_valid && out_addr == 12) && budget < 200) begin
            step();
            budget++;
        end
        check("reach_addr12", out_valid && out_addr == 12, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_out_addr", out_addr, 0);
        saw_done = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done) saw_done = 1'b1;
            if (out_valid) saw_valid = 1'b1;
        end
        check("abort_no_done", saw_done, 0);
        check("abort_no_word", saw_valid, 0);
        run_dump(100, -1, -1, 0, cyc);

        // Randomized contents, backpressure, start re-pulses and writes.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NREG; i++) regs[i] = {$urandom, $urandom};
            run_dump(60, -1, -1, 1, cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
